tcdm_initiator: RTL and testbench

TCDM_INITIATOR -- requirements
Module: tcdm_initiator

---
 rtl/tcdm_initiator.sv | 141 ++++++++++++++
 tb/tb_tcdm_initiator.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_initiator.sv
// TCDM initiator: forwards core requests to the interconnect and returns responses in issue order.
// Optional build macro TCDM_INITIATOR_META_CHECK_EN drops foreign-id responses and pulses err_o.
module tcdm_initiator #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumSlots  = 4,
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned InitId    = 0,
  localparam int unsigned BeWidth   = DataWidth / 8,
  localparam int unsigned TagWidth  = $clog2(NumSlots),
  localparam int unsigned MetaWidth = IdWidth + TagWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [3:0]           req_amo_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AddrWidth-1:0] out_address_o,
  output logic                 out_write_o,
  output logic [3:0]           out_amo_o,
  output logic [DataWidth-1:0] out_wdata_o,
  output logic [BeWidth-1:0]   out_be_o,
  output logic [MetaWidth-1:0] out_meta_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_rdata_i,
  input  logic [MetaWidth-1:0] in_meta_i,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PENDING,
    SLOT_DONE
  } slot_state_e;

  localparam logic [IdWidth-1:0] OwnId = IdWidth'(InitId);

  slot_state_e          state_q [NumSlots];
  slot_state_e          state_d [NumSlots];
  logic [DataWidth-1:0] data_q  [NumSlots];
  logic [DataWidth-1:0] data_d  [NumSlots];
  logic [TagWidth-1:0]  head_q, head_d, tail_q, tail_d;

  logic                 posted, full, alloc, pop, rsp_pending, rsp_hit;
  logic [TagWidth-1:0]  rsp_tag;
  logic [IdWidth-1:0]   rsp_id;

  assign posted = req_write_i && (req_amo_i == 4'd0);

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < NumSlots; i++) begin
      if (state_q[i] == SLOT_FREE) full = 1'b0;
    end
  end

  // Posted stores never need a slot, so they bypass the full stall.
  assign out_valid_o   = req_valid_i && (posted || !full);
  assign req_ready_o   = out_ready_i && (posted || !full);
  assign out_address_o = req_addr_i;
  assign out_write_o   = req_write_i;
  assign out_amo_o     = req_amo_i;
  assign out_wdata_o   = req_wdata_i;
  assign out_be_o      = req_be_i;
  assign out_meta_o    = {OwnId, (posted ? {TagWidth{1'b0}} : tail_q)};

  assign alloc        = req_valid_i && req_ready_o && !posted;
  assign resp_valid_o = (state_q[head_q] == SLOT_DONE);
  assign resp_rdata_o = data_q[head_q];
  assign pop          = resp_valid_o && resp_ready_i;
  assign in_ready_o   = 1'b1;

  assign rsp_tag     = in_meta_i[TagWidth-1:0];
  assign rsp_id      = in_meta_i[MetaWidth-1:TagWidth];
  assign rsp_pending = (state_q[rsp_tag] == SLOT_PENDING);

`ifdef TCDM_INITIATOR_META_CHECK_EN
  logic err_q;

  assign rsp_hit = in_valid_i && rsp_pending && (rsp_id == OwnId);
  assign err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= in_valid_i && !rsp_hit;
  end
`else
  logic unused_id;

  assign rsp_hit   = in_valid_i && rsp_pending;
  assign err_o     = 1'b0;
  assign unused_id = ^rsp_id;
`endif

  // Response, pop and allocate always target distinct slots (PENDING, DONE, FREE).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (rsp_hit) begin
      state_d[rsp_tag] = SLOT_DONE;
      data_d[rsp_tag]  = in_rdata_i;
    end
    if (pop) begin
      state_d[head_q] = SLOT_FREE;
      head_d          = head_q + TagWidth'(1);
    end
    if (alloc) begin
      state_d[tail_q] = SLOT_PENDING;
      tail_d          = tail_q + TagWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i] <= SLOT_FREE;
        data_q[i]  <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_tcdm_initiator.sv
// Self-checking bench for tcdm_initiator: vector table, directed corner sequences and
// randomized traffic against a queue-based model of in-order response delivery.
module tb_tcdm_initiator;

  localparam int NUM_SLOTS = 4;
  localparam logic [7:0] OWN_ID = 8'h3C;
  localparam logic [7:0] BAD_ID = 8'h3D;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid, req_write, resp_ready, out_ready, in_valid;
  logic [31:0] req_addr, req_wdata, in_rdata;
  logic [3:0]  req_amo, req_be;
  logic [9:0]  in_meta;
  logic        req_ready_o, resp_valid_o, out_valid_o, out_write_o, in_ready_o, err_o;
  logic [31:0] resp_rdata_o, out_address_o, out_wdata_o;
  logic [3:0]  out_amo_o, out_be_o;
  logic [9:0]  out_meta_o;

  always #5 clk_i = ~clk_i;

  tcdm_initiator #(
    .AddrWidth(32), .DataWidth(32), .NumSlots(NUM_SLOTS), .IdWidth(8), .InitId(32'h3C)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_amo_i(req_amo), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_address_o(out_address_o),
    .out_write_o(out_write_o), .out_amo_o(out_amo_o), .out_wdata_o(out_wdata_o),
    .out_be_o(out_be_o), .out_meta_o(out_meta_o),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_rdata_i(in_rdata),
    .in_meta_i(in_meta), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: issue-order queue of outstanding requests plus the next tag to hand out.
  typedef struct {
    logic [1:0]  tag;
    bit          got;
    logic [31:0] data;
  } entry_t;

  entry_t mq[$];
  int     m_tail = 0;
  bit     m_err = 1'b0;

  typedef struct {
    logic        rv;
    logic        wr;
    logic [3:0]  amo;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ordy;
    logic        exp_ov;
    logic        exp_rdy;
    logic [1:0]  exp_tag;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk_vec(input logic rv, input logic wr, input logic [3:0] amo,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic ordy, input logic exp_ov, input logic exp_rdy,
                                  input logic [1:0] exp_tag);
    vec_t v;
    v.rv = rv; v.wr = wr; v.amo = amo; v.addr = addr; v.wdata = wdata; v.ordy = ordy;
    v.exp_ov = exp_ov; v.exp_rdy = exp_rdy; v.exp_tag = exp_tag;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic wr, input logic [3:0] amo,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic ordy, input logic rrdy, input logic iv,
                               input logic [1:0] itag, input logic [7:0] iid,
                               input logic [31:0] idata);
    req_valid  = rv;
    req_write  = wr;
    req_amo    = amo;
    req_addr   = addr;
    req_wdata  = wdata;
    req_be     = 4'($urandom);
    out_ready  = ordy;
    resp_ready = rrdy;
    in_valid   = iv;
    in_meta    = {iid, itag};
    in_rdata   = idata;
  endtask

  function automatic bit m_posted();
    return req_write && (req_amo == 4'd0);
  endfunction

  function automatic bit m_open();
    return m_posted() || (mq.size() < NUM_SLOTS);
  endfunction

  function automatic bit m_resp_valid();
    return (mq.size() > 0) && mq[0].got;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_check();
    checkOutput("out_valid", out_valid_o, req_valid && m_open());
    checkOutput("req_ready", req_ready_o, out_ready && m_open());
    checkOutput("out_meta", out_meta_o, {OWN_ID, (m_posted() ? 2'd0 : 2'(m_tail))});
    checkOutput("in_ready", in_ready_o, 1'b1);
    checkOutput("resp_valid", resp_valid_o, m_resp_valid());
    if (m_resp_valid()) checkOutput("resp_rdata", resp_rdata_o, mq[0].data);
    checkOutput("err", err_o, m_err);
  endtask

  task automatic model_update();
    bit rv, acc, hit, id_ok;
    int idx;
    entry_t e;
    rv  = m_resp_valid();
    acc = req_valid && out_ready && m_open() && !m_posted();
    hit = 1'b0;
    if (in_valid) begin
      idx = -1;
      foreach (mq[i]) if (idx < 0 && mq[i].tag == in_meta[1:0] && !mq[i].got) idx = i;
`ifdef TCDM_INITIATOR_META_CHECK_EN
      id_ok = (in_meta[9:2] == OWN_ID);
`else
      id_ok = 1'b1;
`endif
      if (idx >= 0 && id_ok) begin
        mq[idx].got  = 1'b1;
        mq[idx].data = in_rdata;
        hit = 1'b1;
      end
    end
`ifdef TCDM_INITIATOR_META_CHECK_EN
    m_err = in_valid && !hit;
`else
    m_err = 1'b0;
`endif
    if (rv && resp_ready) void'(mq.pop_front());
    if (acc) begin
      e.tag = 2'(m_tail); e.got = 1'b0; e.data = '0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % NUM_SLOTS;
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rrdy);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, rrdy, 1'b0, 2'd0, OWN_ID, 32'd0);
  endtask

  initial begin
    logic [31:0] dvals[4];
    int order[4];
    logic [1:0] pend[$];
    logic [1:0] tag;

    vecs[0] = mk_vec(1, 0, 4'h0, 32'h100, 32'h0,  1, 1, 1, 2'd0);
    vecs[1] = mk_vec(1, 0, 4'h5, 32'h104, 32'h7,  1, 1, 1, 2'd1);
    vecs[2] = mk_vec(1, 1, 4'h0, 32'h108, 32'h9,  0, 1, 0, 2'd0);
    vecs[3] = mk_vec(1, 0, 4'hA, 32'h10C, 32'h0,  1, 1, 1, 2'd2);
    vecs[4] = mk_vec(1, 0, 4'h0, 32'h110, 32'h0,  0, 1, 0, 2'd3);
    vecs[5] = mk_vec(1, 1, 4'hB, 32'h114, 32'h1,  1, 1, 1, 2'd3);
    vecs[6] = mk_vec(1, 0, 4'h0, 32'h118, 32'h0,  1, 0, 0, 2'd0);
    vecs[7] = mk_vec(1, 1, 4'h0, 32'h200, 32'h55, 1, 1, 1, 2'd0);
    vecs[8] = mk_vec(1, 1, 4'h3, 32'h204, 32'h2,  1, 0, 0, 2'd0);
    vecs[9] = mk_vec(0, 1, 4'h0, 32'h208, 32'h0,  1, 0, 1, 2'd0);

    dvals[0] = 32'hA0A0_0000; dvals[1] = 32'hB1B1_1111;
    dvals[2] = 32'hC2C2_2222; dvals[3] = 32'hD3D3_3333;
    order[0] = 3; order[1] = 1; order[2] = 0; order[3] = 2;

    // Reset state.
    idle(1'b0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_resp_valid", resp_valid_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_req_ready", req_ready_o, 1'b1);
    checkOutput("rst_out_valid", out_valid_o, 1'b0);
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;

    // Vector table: fill all slots, then posted and non-posted traffic while full.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].wr, vecs[i].amo, vecs[i].addr, vecs[i].wdata,
                    vecs[i].ordy, 1'b0, 1'b0, 2'd0, OWN_ID, 32'd0);
      settle();
      checkOutput($sformatf("vec%0d_out_valid", i), out_valid_o, vecs[i].exp_ov);
      checkOutput($sformatf("vec%0d_req_ready", i), req_ready_o, vecs[i].exp_rdy);
      checkOutput($sformatf("vec%0d_meta", i), out_meta_o, {OWN_ID, vecs[i].exp_tag});
      checkOutput($sformatf("vec%0d_addr", i), out_address_o, vecs[i].addr);
      checkOutput($sformatf("vec%0d_fields", i), {out_write_o, out_amo_o, out_be_o, out_wdata_o},
                  {vecs[i].wr, vecs[i].amo, req_be, vecs[i].wdata});
      checkOutput($sformatf("vec%0d_resp_valid", i), resp_valid_o, 1'b0);
      tick();
    end

    // Out-of-order responses 3,1,0,2 while a fifth load stalls.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h300, 32'd0, 1'b1, 1'b0, 1'b1,
                    2'(order[k]), OWN_ID, dvals[order[k]]);
      settle();
      checkOutput("ooo_stall_ready", req_ready_o, 1'b0);
      checkOutput("ooo_resp_valid", resp_valid_o, k == 3);
      model_check();
      tick();
    end

    // Core back-pressure: response held with stable data.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h300, 32'd0, 1'b1, 1'b0, 1'b0, 2'd0, OWN_ID, 32'd0);
      settle();
      checkOutput("hold_valid", resp_valid_o, 1'b1);
      checkOutput("hold_rdata", resp_rdata_o, dvals[0]);
      checkOutput("hold_ready", req_ready_o, 1'b0);
      model_check();
      tick();
    end

    // First pop: the freed slot only opens the request port on the next cycle.
    applyStimulus(1'b1, 1'b0, 4'd0, 32'h300, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, OWN_ID, 32'd0);
    settle();
    checkOutput("pop0_ready_same_cycle", req_ready_o, 1'b0);
    checkOutput("pop0_rdata", resp_rdata_o, dvals[0]);
    model_check();
    tick();
    for (int k = 1; k < 4; k++) begin
      applyStimulus(k == 1, 1'b0, 4'd0, 32'h300, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, OWN_ID, 32'd0);
      settle();
      if (k == 1) begin
        checkOutput("fifth_ready", req_ready_o, 1'b1);
        checkOutput("fifth_meta", out_meta_o, {OWN_ID, 2'd0});
      end
      checkOutput("order_valid", resp_valid_o, 1'b1);
      checkOutput($sformatf("order_rdata%0d", k), resp_rdata_o, dvals[k]);
      model_check();
      tick();
    end
    idle(1'b1);
    settle();
    checkOutput("drained_valid", resp_valid_o, 1'b0);
    model_check();
    tick();

    // Response carrying a foreign id for pending tag 0.
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 2'd0, BAD_ID, 32'hCAFE_F00D);
    settle();
    model_check();
    tick();
    idle(1'b0);
    settle();
`ifdef TCDM_INITIATOR_META_CHECK_EN
    checkOutput("badid_err", err_o, 1'b1);
    checkOutput("badid_dropped", resp_valid_o, 1'b0);
`else
    checkOutput("badid_err", err_o, 1'b0);
    checkOutput("badid_accepted", resp_valid_o, 1'b1);
    checkOutput("badid_rdata", resp_rdata_o, 32'hCAFE_F00D);
`endif
    model_check();
    tick();
    settle();
    checkOutput("err_pulse_end", err_o, 1'b0);
    model_check();
    tick();
`ifdef TCDM_INITIATOR_META_CHECK_EN
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 2'd0, OWN_ID, 32'h1234_5678);
    settle();
    model_check();
    tick();
`endif
    for (int k = 0; k < 8 && mq.size() > 0; k++) begin
      idle(1'b1);
      settle();
      model_check();
      tick();
    end

    // Reset with three loads outstanding; a late response must be ignored.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h400 + 32'(k * 4), 32'd0, 1'b1, 1'b0, 1'b0, 2'd0,
                    OWN_ID, 32'd0);
      settle();
      model_check();
      tick();
    end
    idle(1'b0);
    settle();
    rst_ni = 1'b0;
    #1;
    checkOutput("rst2_resp_valid", resp_valid_o, 1'b0);
    checkOutput("rst2_err", err_o, 1'b0);
    checkOutput("rst2_req_ready", req_ready_o, 1'b1);
    checkOutput("rst2_meta", out_meta_o, {OWN_ID, 2'd0});
    @(posedge clk_i);
    #1;
    model_reset();
    rst_ni = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 2'd1, OWN_ID, 32'hBAD0_BAD0);
    settle();
    model_check();
    tick();
    for (int k = 0; k < 2; k++) begin
      idle(1'b1);
      settle();
      checkOutput("late_resp_dropped", resp_valid_o, 1'b0);
      model_check();
      tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      pend.delete();
      foreach (mq[i]) if (!mq[i].got) pend.push_back(mq[i].tag);
      if (pend.size() > 0 && ($urandom % 4) != 0) tag = pend[$urandom % pend.size()];
      else tag = 2'($urandom);
      applyStimulus(($urandom % 10) < 7, 1'($urandom),
                    (($urandom % 3) == 0) ? 4'($urandom_range(1, 11)) : 4'd0,
                    $urandom, $urandom, ($urandom % 5) != 0, ($urandom % 5) < 3,
                    1'($urandom), tag, (($urandom % 10) == 0) ? BAD_ID : OWN_ID, $urandom);
      settle();
      model_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
